apb_reg_slave: RTL

APB_REG_SLAVE -- requirements
Module: apb_reg_slave

---
 rtl/apb_reg_pkg.sv | 26 ++
 rtl/apb_reg_slave.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/apb_reg_pkg.sv
// Shared constants for the APB register slave: register map, ID default, FSM states.
package apb_reg_pkg;

  localparam logic [31:0] ID_VALUE_DEF  = 32'h4150_4231;

  localparam logic [31:0] ADDR_NUM      = 32'h0000_0000;
  localparam logic [31:0] ADDR_DATE     = 32'h0000_0004;
  localparam logic [31:0] ADDR_SURNAME  = 32'h0000_0008;
  localparam logic [31:0] ADDR_NAME     = 32'h0000_000C;
  localparam logic [31:0] ADDR_WR_CNT   = 32'h0000_0010;
  localparam logic [31:0] ADDR_ID       = 32'h0000_0014;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Misaligned, out-of-map, or a write aimed at a read-only register.
  function automatic logic addr_err(input logic [31:0] addr, input logic wr);
    return (addr[1:0] != 2'b00) || (addr > ADDR_ID) ||
           (wr && ((addr == ADDR_WR_CNT) || (addr == ADDR_ID)));
  endfunction

endpackage

// File: rtl/apb_reg_slave.sv
// APB slave with four RW registers, a committed-write counter and a constant ID.
// state    | meaning
// ST_IDLE  | bus idle, waiting for a setup phase (PSEL=1, PENABLE=0)
// ST_SETUP | request latched, waiting for PENABLE
// ST_WAIT  | PREADY held low for WAIT_STATES cycles
// ST_RESP  | PREADY=1 for one cycle, write commits on the closing edge
module apb_reg_slave
  import apb_reg_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DEF
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam logic [3:0] WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic        capture;
  logic [31:0] addr_q, wdata_q;
  logic        write_q;
  logic [31:0] num, date, surname, name, wr_cnt;
  logic [31:0] rd_mux;
  logic        resp, err, commit;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    capture      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_nxt = ST_SETUP;
          capture   = 1'b1;
        end
      end
      ST_SETUP: begin
        if (!PSEL) begin
          state_nxt = ST_IDLE;
        end else if (PENABLE) begin
          if (WAIT_STATES == 0) begin
            state_nxt = ST_RESP;
          end else begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WS_LOAD;
          end
        end else begin
          capture = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_nxt    = ST_IDLE;
          wait_cnt_nxt = 4'd0;
        end else if (wait_cnt == 4'd0) begin
          state_nxt = ST_RESP;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (PSEL && !PENABLE) begin
          state_nxt = ST_SETUP;
          capture   = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 32'd0;
    case (addr_q)
      ADDR_NUM:     rd_mux = num;
      ADDR_DATE:    rd_mux = date;
      ADDR_SURNAME: rd_mux = surname;
      ADDR_NAME:    rd_mux = name;
      ADDR_WR_CNT:  rd_mux = wr_cnt;
      ADDR_ID:      rd_mux = ID_VALUE;
      default:      rd_mux = 32'd0;
    endcase
  end

  assign resp    = (state == ST_RESP);
  assign err     = addr_err(addr_q, write_q);
  assign commit  = resp && write_q && !err;
  assign PREADY  = resp;
  assign PSLVERR = resp && err;
  assign PRDATA  = (resp && !err && !write_q) ? rd_mux : 32'd0;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= 32'd0;
      write_q  <= 1'b0;
      wdata_q  <= 32'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (capture) begin
        addr_q  <= PADDR;
        write_q <= PWRITE;
        wdata_q <= PWDATA;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      num     <= 32'd0;
      date    <= 32'd0;
      surname <= 32'd0;
      name    <= 32'd0;
      wr_cnt  <= 32'd0;
    end else if (commit) begin
      wr_cnt <= wr_cnt + 32'd1;
      case (addr_q)
        ADDR_NUM:     num     <= wdata_q;
        ADDR_DATE:    date    <= wdata_q;
        ADDR_SURNAME: surname <= wdata_q;
        ADDR_NAME:    name    <= wdata_q;
        default:      ;
      endcase
    end
  end

endmodule
